// File: rtl/alarm_set_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_set_ctrl
//
// Purpose:
//   User-interface sequencer for the alarm register. Turns the debounced
//   mode / increment button levels into single-cycle hours / minutes
//   increment strobes. Provides IDLE -> SET_HR -> SET_MIN -> IDLE mode
//   stepping, hold-to-auto-repeat, an inactivity timeout back to IDLE and a
//   display blink flag. All timing is counted in tick_1khz strobes.
//
// Ports:
//   sys_clk_i                system clock, all logic on its rising edge
//   rst_i                    synchronous active-high reset
//   tick_1khz_i              one-cycle timebase strobe
//   btn_mode_i               debounced mode button level, 1 = pressed
//   btn_inc_i                debounced increment button level, 1 = pressed
//   inc_alarm_hours_en_o     one-cycle hours-increment strobe (registered)
//   inc_alarm_minutes_en_o   one-cycle minutes-increment strobe (registered)
//   set_state_o              00 IDLE, 01 SET_HR, 10 SET_MIN
//   blink_o                  display blink phase, 0 in IDLE
//   alarm_armed_o            alarm enable flag
//
// Configuration macro:
//   ALARM_ARM_TOGGLE_EN  defined   -> increment presses in IDLE toggle
//                                      alarm_armed_o (reset value 0)
//                        undefined -> alarm_armed_o tied to 1, increment
//                                      presses in IDLE are ignored
// ---------------------------------------------------------------------------
module alarm_set_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 500,
  parameter int unsigned REPEAT_RATE   = 150,
  parameter int unsigned TIMEOUT_TICKS = 10000,
  parameter int unsigned BLINK_TICKS   = 250
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       tick_1khz_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic       inc_alarm_hours_en_o,
  output logic       inc_alarm_minutes_en_o,
  output logic [1:0] set_state_o,
  output logic       blink_o,
  output logic       alarm_armed_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_e;

  localparam logic [15:0] RptDelay   = 16'(REPEAT_DELAY);
  localparam logic [15:0] TimeoutLim = 16'(TIMEOUT_TICKS);
  localparam logic [15:0] BlinkLim   = 16'(BLINK_TICKS);
  // After an auto-repeat strobe the counter restarts part-way so that the
  // next strobe lands REPEAT_RATE ticks later; a rate not below the delay
  // simply restarts from zero.
  localparam logic [15:0] RptReload  = (REPEAT_DELAY > REPEAT_RATE) ?
                                       16'(REPEAT_DELAY - REPEAT_RATE) : 16'd0;

  state_e      state_q, state_d;
  logic        modePrev_q, incPrev_q;
  logic        hrStrobe_q, hrStrobe_d;
  logic        minStrobe_q, minStrobe_d;
  logic        blink_q, blink_d;
  logic [15:0] rptCnt_q, rptCnt_d;
  logic [15:0] toCnt_q, toCnt_d;
  logic [15:0] blinkCnt_q, blinkCnt_d;

  logic        riseMode, riseInc, inSet;
  logic [15:0] rptNext, toNext, blinkNext;
  logic        strobe, countBlink;

  // Previous-button registers clear on reset, so a button held across
  // reset is seen as a fresh press on the first cycle afterwards.
  assign riseMode  = btn_mode_i & ~modePrev_q;
  assign riseInc   = btn_inc_i & ~incPrev_q;
  assign inSet     = (state_q != IDLE);
  assign rptNext   = rptCnt_q + 16'd1;
  assign toNext    = toCnt_q + 16'd1;
  assign blinkNext = blinkCnt_q + 16'd1;

`ifdef ALARM_ARM_TOGGLE_EN
  logic armed_q, armed_d;
`endif

  // Next-state logic. Priority inside a cycle: a mode edge beats
  // everything, then an inc edge or auto-repeat strobe, then the timeout.
  // Whenever an edge or strobe clears a counter, a coincident tick is not
  // added to it.
  always_comb begin
    state_d     = state_q;
    hrStrobe_d  = 1'b0;
    minStrobe_d = 1'b0;
    blink_d     = blink_q;
    rptCnt_d    = rptCnt_q;
    toCnt_d     = toCnt_q;
    blinkCnt_d  = blinkCnt_q;
    strobe      = 1'b0;
    countBlink  = 1'b0;
`ifdef ALARM_ARM_TOGGLE_EN
    armed_d     = armed_q;
`endif

    if (riseMode) begin
      rptCnt_d = 16'd0;
      toCnt_d  = 16'd0;
      case (state_q)
        IDLE: begin
          state_d    = SET_HR;
          blink_d    = 1'b1;
          blinkCnt_d = 16'd0;
        end
        SET_HR: begin
          // blink phase carries over into SET_MIN
          state_d    = SET_MIN;
          countBlink = 1'b1;
        end
        default: begin
          state_d    = IDLE;
          blink_d    = 1'b0;
          blinkCnt_d = 16'd0;
        end
      endcase
    end else if (inSet) begin
      countBlink = 1'b1;
      if (riseInc) begin
        strobe   = 1'b1;
        rptCnt_d = 16'd0;
      end else if (btn_inc_i) begin
        if (tick_1khz_i) begin
          if (rptNext == RptDelay) begin
            strobe   = 1'b1;
            rptCnt_d = RptReload;
          end else begin
            rptCnt_d = rptNext;
          end
        end
      end else begin
        rptCnt_d = 16'd0;
      end

      if (strobe) begin
        toCnt_d = 16'd0;
      end else if (tick_1khz_i) begin
        if (toNext == TimeoutLim) begin
          state_d    = IDLE;
          rptCnt_d   = 16'd0;
          toCnt_d    = 16'd0;
          blinkCnt_d = 16'd0;
          blink_d    = 1'b0;
          countBlink = 1'b0;
        end else begin
          toCnt_d = toNext;
        end
      end
`ifdef ALARM_ARM_TOGGLE_EN
    end else if (riseInc) begin
      armed_d = ~armed_q;
`endif
    end

    if (countBlink && tick_1khz_i) begin
      if (blinkNext == BlinkLim) begin
        blink_d    = ~blink_q;
        blinkCnt_d = 16'd0;
      end else begin
        blinkCnt_d = blinkNext;
      end
    end

    hrStrobe_d  = strobe && (state_q == SET_HR);
    minStrobe_d = strobe && (state_q == SET_MIN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      modePrev_q  <= 1'b0;
      incPrev_q   <= 1'b0;
      hrStrobe_q  <= 1'b0;
      minStrobe_q <= 1'b0;
      blink_q     <= 1'b0;
      rptCnt_q    <= 16'd0;
      toCnt_q     <= 16'd0;
      blinkCnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      modePrev_q  <= btn_mode_i;
      incPrev_q   <= btn_inc_i;
      hrStrobe_q  <= hrStrobe_d;
      minStrobe_q <= minStrobe_d;
      blink_q     <= blink_d;
      rptCnt_q    <= rptCnt_d;
      toCnt_q     <= toCnt_d;
      blinkCnt_q  <= blinkCnt_d;
    end
  end

`ifdef ALARM_ARM_TOGGLE_EN
  // Arm flag, toggled by increment presses while in IDLE.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign alarm_armed_o = armed_q;
`else
  assign alarm_armed_o = 1'b1;
`endif

  assign inc_alarm_hours_en_o   = hrStrobe_q;
  assign inc_alarm_minutes_en_o = minStrobe_q;
  assign set_state_o            = state_q;
  assign blink_o                = blink_q;

endmodule
